// File: rtl/bcd_pkg.sv
// Shared definitions for the serial binary-to-BCD converter.
//   DIGIT_W     : width of one BCD digit
//   ADD3_THRESH : double-dabble correction threshold (digit >= 5 gets +3)
//   ADD3_VAL    : correction amount
//   bcd_state_t : converter FSM states
//   pow10()     : elaboration-time helper for the range check
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;
    localparam logic [DIGIT_W-1:0] ADD3_VAL = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_serial_if.sv
// Handshake bundle of the serial BCD converter.
//   in_valid/in_ready/din     : operand channel (master drives in_valid, din)
//   out_valid/out_ready/dout  : result channel (master drives out_ready)
//   sign                      : result sign, only with BCD_SERIAL_SIGNED_EN
// master = producer/consumer environment, slave = converter.
interface bcd_serial_if #(
    parameter int WIDTH  = 9,
    parameter int DIGITS = 3
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      din;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   dout;
`ifdef BCD_SERIAL_SIGNED_EN
    logic                  sign;
`endif

    modport master (
        output in_valid, din, out_ready,
`ifdef BCD_SERIAL_SIGNED_EN
        input  sign,
`endif
        input  in_ready, out_valid, dout
    );

    modport slave (
        input  in_valid, din, out_ready,
`ifdef BCD_SERIAL_SIGNED_EN
        output sign,
`endif
        output in_ready, out_valid, dout
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is >= 5 so that
// the following left shift carries correctly into the next digit.
//   din  : digit before correction
//   dout : corrected digit
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);
    assign dout = (din >= ADD3_THRESH) ? (din + ADD3_VAL) : din;
endmodule

// File: rtl/bcd_serial.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock.
// Optional macro BCD_SERIAL_SIGNED_EN: operand is two's complement, its
// magnitude is converted and the sign is reported on bus.sign.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : bcd_serial_if slave (operand in, packed BCD result out)
module bcd_serial
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 9,
    parameter int DIGITS = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    bcd_serial_if.slave  bus
);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int AW  = DIGIT_W * DIGITS;
    localparam longint unsigned MAX_IN = (64'd1 << WIDTH) - 64'd1;

    if (WIDTH < 2 || WIDTH > 31) begin : g_width_err
        $error("bcd_serial: WIDTH must be in 2..31");
    end
    if (pow10(DIGITS) <= MAX_IN) begin : g_range_err
        $error("bcd_serial: DIGITS too small for the WIDTH-bit input range");
    end

    bcd_state_t        state_q, state_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     dout_q, dout_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [AW-1:0]     acc_adj;
    logic [AW+WIDTH-1:0] shifted;
    logic [WIDTH-1:0]  operand;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (acc_q[gi*DIGIT_W +: DIGIT_W]),
            .dout (acc_adj[gi*DIGIT_W +: DIGIT_W])
        );
    end

    assign shifted = {acc_adj, sr_q} << 1;

`ifdef BCD_SERIAL_SIGNED_EN
    // Sign captured at acceptance, published together with dout at completion.
    logic sign_pend_q, sign_pend_d;
    logic sign_q, sign_d;
    // Negating the most negative value wraps to 2**(WIDTH-1), which is the
    // correct unsigned magnitude in WIDTH bits.
    assign operand = bus.din[WIDTH-1] ? (~bus.din + WIDTH'(1)) : bus.din;
    assign bus.sign = sign_q;
`else
    assign operand = bus.din;
`endif

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        dout_d      = dout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef BCD_SERIAL_SIGNED_EN
        sign_pend_d = sign_pend_q;
        sign_d      = sign_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sr_d       = operand;
                    acc_d      = '0;
                    cnt_d      = CW'(WIDTH);
                    state_d    = SHIFT;
                    in_ready_d = 1'b0;
`ifdef BCD_SERIAL_SIGNED_EN
                    sign_pend_d = bus.din[WIDTH-1];
`endif
                end
            end
            SHIFT: begin
                acc_d = shifted[AW+WIDTH-1 -: AW];
                sr_d  = shifted[WIDTH-1:0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    // Last bit: publish the result on the same edge.
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    dout_d      = shifted[AW+WIDTH-1 -: AW];
`ifdef BCD_SERIAL_SIGNED_EN
                    sign_d      = sign_pend_q;
`endif
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            dout_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef BCD_SERIAL_SIGNED_EN
            sign_pend_q <= 1'b0;
            sign_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef BCD_SERIAL_SIGNED_EN
            sign_pend_q <= sign_pend_d;
            sign_q      <= sign_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
endmodule
